// File: rtl/piano_pkg.sv
// Shared definitions for the piano datapath: note codes, mode encoding,
// sequencer states and the event-entry layout.
package piano_pkg;

    localparam int OCT_W  = 3;
    localparam int NOTE_W = 3;

    typedef enum logic [2:0] {
        NOTE_REST = 3'd0,
        NOTE_C    = 3'd1,
        NOTE_D    = 3'd2,
        NOTE_E    = 3'd3,
        NOTE_F    = 3'd4,
        NOTE_G    = 3'd5,
        NOTE_A    = 3'd6,
        NOTE_B    = 3'd7
    } note_t;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_REC  = 2'd1,
        MODE_PLAY = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REC        = 2'd1,
        ST_PLAY_FETCH = 2'd2,
        ST_PLAY_HOLD  = 2'd3
    } seq_state_t;

    // An event entry is {octave, note, duration}.
    function automatic int event_width(input int dur_w);
        return OCT_W + NOTE_W + dur_w;
    endfunction

    // Both playback states report as PLAY.
    function automatic mode_t state_to_mode(input seq_state_t s);
        case (s)
            ST_IDLE: return MODE_IDLE;
            ST_REC:  return MODE_REC;
            default: return MODE_PLAY;
        endcase
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control/status bundle between the keyboard front end, the sequencer
// and the amplifier. master drives live input and pulses; slave is the
// sequencer.
interface note_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              tick;
    logic [2:0]        live_octave;
    logic [2:0]        live_note;
    logic              rec_toggle;
    logic              play_toggle;
    logic              clear;
    logic [2:0]        out_octave;
    logic [2:0]        out_note;
    logic [1:0]        mode;
    logic [ADDR_W:0]   rec_count;
    logic              full;

    modport master (
        output tick, live_octave, live_note, rec_toggle, play_toggle, clear,
        input  out_octave, out_note, mode, rec_count, full
    );

    modport slave (
        input  tick, live_octave, live_note, rec_toggle, play_toggle, clear,
        output out_octave, out_note, mode, rec_count, full
    );

endinterface

// File: rtl/note_event_ram.sv
// Event buffer: one write port, one read port, registered read data.
// The array is not reset; only entries below rec_count are meaningful.
module note_event_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Store a completed event.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/note_sequencer.sv
// Record/playback controller owning the amplifier's {octave, note} input.
// Live notes pass through (one register of latency), are recorded with
// tick-counted durations, and are replayed with their original timing.
module note_sequencer
    import piano_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DUR_W  = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    note_sequencer_if.slave io_bus
);

    localparam int                EV_W     = event_width(DUR_W);
    localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
    localparam logic [DUR_W-1:0]  DUR_MAX  = '1;
    localparam logic [DUR_W-1:0]  DUR_LAST = DUR_MAX - DUR_ONE;
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    seq_state_t        r_state, w_state_next;
    logic [ADDR_W:0]   r_rec_count, w_rec_count_next;
    logic              r_full, w_full_next;
    logic [2:0]        r_cur_oct, w_cur_oct_next;
    logic [2:0]        r_cur_note, w_cur_note_next;
    logic [DUR_W-1:0]  r_cur_dur, w_cur_dur_next;
    logic [DUR_W-1:0]  r_hold_cnt, w_hold_cnt_next;
    logic [ADDR_W-1:0] r_rd_idx, w_rd_idx_next;
    logic [2:0]        r_out_octave, w_out_octave_next;
    logic [2:0]        r_out_note, w_out_note_next;

    logic [DUR_W-1:0]  w_dur_eff;
    logic              w_hit_max;
    logic              w_live_change;
    logic              w_close_ev;
    logic              w_last_entry;
    logic              w_wr_en;
    logic [EV_W-1:0]   w_wr_data;
    logic [EV_W-1:0]   w_rd_data;
    logic [2:0]        w_rd_oct;
    logic [2:0]        w_rd_note;
    logic [DUR_W-1:0]  w_rd_dur;

    // A tick in the same cycle as a live change still belongs to the old event.
    assign w_dur_eff     = r_cur_dur + (io_bus.tick ? DUR_ONE : '0);
    assign w_hit_max     = io_bus.tick && (r_cur_dur == DUR_LAST);
    assign w_live_change = {io_bus.live_octave, io_bus.live_note} != {r_cur_oct, r_cur_note};
    assign w_close_ev    = w_live_change || io_bus.rec_toggle || w_hit_max;
    assign w_last_entry  = ({1'b0, r_rd_idx} + CNT_ONE) == r_rec_count;
    assign w_wr_data     = {r_cur_oct, r_cur_note, w_dur_eff};
    assign {w_rd_oct, w_rd_note, w_rd_dur} = w_rd_data;

    // The read address runs one cycle ahead (next index) so that the entry is
    // already on the RAM output during PLAY_FETCH.
    note_event_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (EV_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_rec_count[ADDR_W-1:0]),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_rd_idx_next),
        .o_rd_data (w_rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath decode; clear overrides every other pulse.
    always_comb begin
        w_state_next      = r_state;
        w_rec_count_next  = r_rec_count;
        w_full_next       = r_full;
        w_cur_oct_next    = r_cur_oct;
        w_cur_note_next   = r_cur_note;
        w_cur_dur_next    = r_cur_dur;
        w_hold_cnt_next   = r_hold_cnt;
        w_rd_idx_next     = r_rd_idx;
        w_out_octave_next = r_out_octave;
        w_out_note_next   = r_out_note;
        w_wr_en           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (io_bus.play_toggle && (r_rec_count != '0)) begin
                    w_rd_idx_next = '0;
                    w_state_next  = ST_PLAY_FETCH;
                end else if (io_bus.rec_toggle) begin
                    w_rec_count_next = '0;
                    w_full_next      = 1'b0;
                    w_cur_dur_next   = '0;
                    w_cur_oct_next   = io_bus.live_octave;
                    w_cur_note_next  = io_bus.live_note;
                    w_state_next     = ST_REC;
                end
            end

            ST_REC: begin
                w_cur_dur_next = w_dur_eff;
                // Zero-length events are never written.
                if (w_close_ev && (w_dur_eff != '0)) begin
                    w_wr_en          = 1'b1;
                    w_rec_count_next = r_rec_count + CNT_ONE;
                    if (w_rec_count_next == CNT_FULL) begin
                        w_full_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                if (w_live_change) begin
                    w_cur_oct_next  = io_bus.live_octave;
                    w_cur_note_next = io_bus.live_note;
                    w_cur_dur_next  = '0;
                end else if (w_hit_max) begin
                    // Long notes are split into DUR_MAX chunks.
                    w_cur_dur_next = '0;
                end
                if (io_bus.rec_toggle) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_PLAY_FETCH: begin
                w_out_octave_next = w_rd_oct;
                w_out_note_next   = w_rd_note;
                w_hold_cnt_next   = w_rd_dur;
                w_state_next      = io_bus.play_toggle ? ST_IDLE : ST_PLAY_HOLD;
            end

            ST_PLAY_HOLD: begin
                if (io_bus.play_toggle) begin
                    w_state_next = ST_IDLE;
                end else if (io_bus.tick) begin
                    w_hold_cnt_next = r_hold_cnt - DUR_ONE;
                    if (r_hold_cnt <= DUR_ONE) begin
                        if (w_last_entry) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_rd_idx_next = r_rd_idx + IDX_ONE;
                            w_state_next  = ST_PLAY_FETCH;
                        end
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (io_bus.clear) begin
            w_wr_en          = 1'b0;
            w_rec_count_next = '0;
            w_full_next      = 1'b0;
            w_state_next     = ST_IDLE;
        end

        // Outside playback the amplifier follows the live keyboard.
        if ((w_state_next == ST_IDLE) || (w_state_next == ST_REC)) begin
            w_out_octave_next = io_bus.live_octave;
            w_out_note_next   = io_bus.live_note;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec_count  <= '0;
            r_full       <= 1'b0;
            r_cur_oct    <= '0;
            r_cur_note   <= NOTE_REST;
            r_cur_dur    <= '0;
            r_hold_cnt   <= '0;
            r_rd_idx     <= '0;
            r_out_octave <= '0;
            r_out_note   <= NOTE_REST;
        end else begin
            r_rec_count  <= w_rec_count_next;
            r_full       <= w_full_next;
            r_cur_oct    <= w_cur_oct_next;
            r_cur_note   <= w_cur_note_next;
            r_cur_dur    <= w_cur_dur_next;
            r_hold_cnt   <= w_hold_cnt_next;
            r_rd_idx     <= w_rd_idx_next;
            r_out_octave <= w_out_octave_next;
            r_out_note   <= w_out_note_next;
        end
    end

    assign io_bus.out_octave = r_out_octave;
    assign io_bus.out_note   = r_out_note;
    assign io_bus.mode       = state_to_mode(r_state);
    assign io_bus.rec_count  = r_rec_count;
    assign io_bus.full       = r_full;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a default instance, a DEPTH=4 instance
// and a DUR_W=3 instance, all driven from the same stimulus signals.
module tb_note_sequencer;
    import piano_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       s_tick, s_rec, s_play, s_clr;
    logic [2:0] s_oct, s_note;

    int n_vec = 0;
    int n_err = 0;

    note_sequencer_if #(.ADDR_W(8)) bus_a ();
    note_sequencer_if #(.ADDR_W(2)) bus_b ();
    note_sequencer_if #(.ADDR_W(8)) bus_c ();

    assign bus_a.tick = s_tick;  assign bus_a.live_octave = s_oct;  assign bus_a.live_note = s_note;
    assign bus_a.rec_toggle = s_rec; assign bus_a.play_toggle = s_play; assign bus_a.clear = s_clr;
    assign bus_b.tick = s_tick;  assign bus_b.live_octave = s_oct;  assign bus_b.live_note = s_note;
    assign bus_b.rec_toggle = s_rec; assign bus_b.play_toggle = s_play; assign bus_b.clear = s_clr;
    assign bus_c.tick = s_tick;  assign bus_c.live_octave = s_oct;  assign bus_c.live_note = s_note;
    assign bus_c.rec_toggle = s_rec; assign bus_c.play_toggle = s_play; assign bus_c.clear = s_clr;

    note_sequencer #(.DEPTH(256), .ADDR_W(8), .DUR_W(12)) dut_a (.clk(clk), .rst_n(rst_n), .io_bus(bus_a));
    note_sequencer #(.DEPTH(4),   .ADDR_W(2), .DUR_W(12)) dut_b (.clk(clk), .rst_n(rst_n), .io_bus(bus_b));
    note_sequencer #(.DEPTH(256), .ADDR_W(8), .DUR_W(3))  dut_c (.clk(clk), .rst_n(rst_n), .io_bus(bus_c));

    typedef struct packed {
        logic       rec;
        logic       play;
        logic       clr;
        logic       tk;
        logic [2:0] oct;
        logic [2:0] note;
        logic [1:0] e_mode;
        logic       chk_out;
        logic [2:0] e_oct;
        logic [2:0] e_note;
        logic [8:0] e_cnt;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic p, input logic c, input logic t,
                                input logic [2:0] o, input logic [2:0] n,
                                input logic [1:0] m, input logic co,
                                input logic [2:0] eo, input logic [2:0] en,
                                input logic [8:0] ec);
        vec_t v;
        v.rec = r; v.play = p; v.clr = c; v.tk = t; v.oct = o; v.note = n;
        v.e_mode = m; v.chk_out = co; v.e_oct = eo; v.e_note = en; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic p, input logic c, input logic t);
        s_rec = r; s_play = p; s_clr = c; s_tick = t;
        step();
        s_rec = 1'b0; s_play = 1'b0; s_clr = 1'b0; s_tick = 1'b0;
    endtask

    int         n_seen;
    logic [2:0] seen [8];
    logic       done;

    initial begin
        // rec play clr tk  oct note | mode chk oct note cnt
        vecs[0]  = mk(0,0,0,0, 4,1, 0,1,4,1,0);
        vecs[1]  = mk(1,0,0,0, 4,1, 1,1,4,1,0);
        vecs[2]  = mk(0,0,0,1, 4,1, 1,1,4,1,0);
        vecs[3]  = mk(0,0,0,1, 4,1, 1,1,4,1,0);
        vecs[4]  = mk(0,1,0,1, 4,1, 1,1,4,1,0);
        vecs[5]  = mk(0,0,0,1, 4,1, 1,1,4,1,0);
        vecs[6]  = mk(0,0,0,1, 4,1, 1,1,4,1,0);
        vecs[7]  = mk(0,0,0,0, 4,3, 1,1,4,3,1);
        vecs[8]  = mk(0,0,0,1, 4,3, 1,1,4,3,1);
        vecs[9]  = mk(0,0,0,1, 4,3, 1,1,4,3,1);
        vecs[10] = mk(0,0,0,1, 4,3, 1,1,4,3,1);
        vecs[11] = mk(1,0,0,0, 4,3, 0,1,4,3,2);
        vecs[12] = mk(0,1,0,0, 2,6, 2,0,0,0,2);
        vecs[13] = mk(0,0,0,1, 2,6, 2,1,4,1,2);
        vecs[14] = mk(0,0,0,1, 2,6, 2,1,4,1,2);
        vecs[15] = mk(0,0,0,1, 2,6, 2,1,4,1,2);
        vecs[16] = mk(0,0,0,1, 2,6, 2,1,4,1,2);
        vecs[17] = mk(0,0,0,1, 2,6, 2,1,4,1,2);
        vecs[18] = mk(0,0,0,1, 2,6, 2,1,4,1,2);
        vecs[19] = mk(0,0,0,1, 2,6, 2,1,4,3,2);
        vecs[20] = mk(0,0,0,1, 2,6, 2,1,4,3,2);
        vecs[21] = mk(0,0,0,1, 2,6, 2,1,4,3,2);
        vecs[22] = mk(0,0,0,1, 2,6, 0,1,2,6,2);
        vecs[23] = mk(0,0,0,0, 3,2, 0,1,3,2,2);
        vecs[24] = mk(0,1,0,0, 3,2, 2,0,0,0,2);
        vecs[25] = mk(0,0,0,0, 3,2, 2,1,4,1,2);
        vecs[26] = mk(0,0,0,1, 3,2, 2,1,4,1,2);
        vecs[27] = mk(0,1,0,0, 3,2, 0,1,3,2,2);
        vecs[28] = mk(0,1,1,0, 3,2, 0,1,3,2,0);
        vecs[29] = mk(0,1,0,0, 5,4, 0,1,5,4,0);

        rst_n = 1'b0;
        s_tick = 0; s_rec = 0; s_play = 0; s_clr = 0; s_oct = 0; s_note = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst mode", bus_a.mode, 0);
        check("rst out_note", bus_a.out_note, 0);
        check("rst count", bus_a.rec_count, 0);
        check("rst full", bus_b.full, 0);

        // Reset asserted in the middle of a take: outputs clear without a clock edge.
        s_oct = 4; s_note = 1; cyc(1,0,0,0);
        cyc(0,0,0,1);
        s_note = 2; cyc(0,0,0,0);
        check("pre-rst count", bus_a.rec_count, 1);
        check("pre-rst mode", bus_a.mode, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async mode", bus_a.mode, 0);
        check("async out_oct", bus_a.out_octave, 0);
        check("async out_note", bus_a.out_note, 0);
        check("async count", bus_a.rec_count, 0);
        check("async full", bus_a.full, 0);
        repeat (3) @(posedge clk);
        #1;
        check("held rst mode", bus_a.mode, 0);
        check("held rst out_note", bus_a.out_note, 0);
        rst_n = 1'b1;

        // Record C4 x5, E4 x3, play back, abort, pulse priorities.
        for (int i = 0; i < NV; i++) begin
            s_oct = vecs[i].oct; s_note = vecs[i].note;
            cyc(vecs[i].rec, vecs[i].play, vecs[i].clr, vecs[i].tk);
            check($sformatf("v%0d mode", i), bus_a.mode, vecs[i].e_mode);
            if (vecs[i].chk_out) begin
                check($sformatf("v%0d out_oct", i), bus_a.out_octave, vecs[i].e_oct);
                check($sformatf("v%0d out_note", i), bus_a.out_note, vecs[i].e_note);
            end
            check($sformatf("v%0d count", i), bus_a.rec_count, vecs[i].e_cnt);
        end

        // Zero-length event dropped; tick coinciding with a change counts for the old note.
        cyc(0,0,1,0);
        s_oct = 2; s_note = 7; cyc(1,0,0,0);
        s_note = 1; cyc(0,0,0,0);
        check("zero-len count", bus_a.rec_count, 0);
        cyc(0,0,0,1);
        cyc(0,0,0,1);
        s_note = 2; cyc(0,0,0,1);
        check("coinc count", bus_a.rec_count, 1);
        cyc(1,0,0,0);
        check("coinc stop count", bus_a.rec_count, 1);
        check("coinc stop mode", bus_a.mode, 0);
        check("coinc entry0", dut_a.u_ram.r_mem[0], {3'd2, 3'd1, 12'd3});

        // clear during REC drops the in-progress event.
        cyc(1,0,0,0);
        cyc(0,0,0,1);
        s_note = 3; cyc(0,0,1,0);
        check("clr-rec mode", bus_a.mode, 0);
        check("clr-rec count", bus_a.rec_count, 0);

        // Three entries, then clear+play in IDLE.
        s_oct = 1; s_note = 1; cyc(1,0,0,0);
        cyc(0,0,0,1);
        s_note = 2; cyc(0,0,0,0);
        cyc(0,0,0,1);
        s_note = 3; cyc(0,0,0,0);
        cyc(0,0,0,1);
        cyc(1,0,0,0);
        check("three count", bus_a.rec_count, 3);
        cyc(0,1,1,0);
        check("clr+play count", bus_a.rec_count, 0);
        check("clr+play mode", bus_a.mode, 0);
        cyc(0,0,0,0);
        check("clr+play mode+1", bus_a.mode, 0);

        // DEPTH=4: five distinct one-tick notes fill the buffer after four writes.
        cyc(0,0,1,0);
        s_oct = 3; s_note = 1; cyc(1,0,0,0);
        for (int k = 1; k <= 4; k++) begin
            cyc(0,0,0,1);
            s_note = 3'(k + 1); cyc(0,0,0,0);
            check($sformatf("b write%0d count", k), bus_b.rec_count, k);
            check($sformatf("b write%0d full", k), bus_b.full, (k == 4) ? 1 : 0);
            check($sformatf("b write%0d mode", k), bus_b.mode, (k == 4) ? 0 : 1);
        end
        cyc(0,0,0,1);
        s_note = 6; cyc(0,0,0,0);
        check("b after-full count", bus_b.rec_count, 4);
        check("b after-full full", bus_b.full, 1);

        // Play the full DEPTH=4 buffer back with a tick every cycle.
        cyc(0,1,0,0);
        n_seen = 0; done = 1'b0;
        for (int j = 0; j < 20 && !done; j++) begin
            cyc(0,0,0,1);
            if (bus_b.mode == 2'd0) begin
                done = 1'b1;
            end else if (n_seen == 0 || seen[n_seen-1] != bus_b.out_note) begin
                if (n_seen < 8) seen[n_seen] = bus_b.out_note;
                n_seen++;
            end
        end
        check("b play finished", done, 1);
        check("b play entries", n_seen, 4);
        for (int k = 0; k < 4 && k < n_seen; k++) begin
            check($sformatf("b play note%0d", k), seen[k], k + 1);
        end
        check("b full persists", bus_b.full, 1);

        // DUR_W=3: G4 held 10 ticks splits into 7 + 3.
        cyc(0,0,1,0);
        s_oct = 4; s_note = 5; cyc(1,0,0,0);
        repeat (7) cyc(0,0,0,1);
        check("c split count", bus_c.rec_count, 1);
        repeat (3) cyc(0,0,0,1);
        cyc(1,0,0,0);
        check("c count", bus_c.rec_count, 2);
        check("c mode", bus_c.mode, 0);
        check("c entry0", dut_c.u_ram.r_mem[0], {3'd4, 3'd5, 3'd7});
        check("c entry1", dut_c.u_ram.r_mem[1], {3'd4, 3'd5, 3'd3});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
